// File: rtl/mlp_pkg.sv
// Shared MLP datapath types and the saturating narrow-back helper used by
// every stage that folds a widened accumulator back to the data width.
package mlp_pkg;

   localparam int unsigned DATA_WIDTH = 8;

   typedef logic signed [DATA_WIDTH-1:0] data_t;
   typedef logic signed [DATA_WIDTH:0]   acc_t;

   typedef struct packed {
      logic  sat;
      data_t data;
   } sat_res_t;

   // One extra bit of headroom means overflow shows up exactly as the top two
   // bits disagreeing; the top bit then picks the rail.
   function automatic sat_res_t sat_to_data(acc_t acc);
      sat_res_t res;
      if (acc[DATA_WIDTH] ^ acc[DATA_WIDTH-1]) begin
         res.sat  = 1'b1;
         res.data = {acc[DATA_WIDTH], {(DATA_WIDTH-1){~acc[DATA_WIDTH]}}};
      end else begin
         res.sat  = 1'b0;
         res.data = acc[DATA_WIDTH-1:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/neuron_activation_if.sv
// Stream bundle around the activation stage: sum/bias in, activated result
// out, plus the saturation event counter.
interface neuron_activation_if #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned COUNT_WIDTH = 16
);
   logic signed [DATA_WIDTH-1:0] in_sum;
   logic signed [DATA_WIDTH-1:0] in_bias;
   logic                         in_valid;
   logic                         in_ready;
   logic signed [DATA_WIDTH-1:0] out_data;
   logic                         out_sat;
   logic                         out_valid;
   logic                         out_ready;
   logic [COUNT_WIDTH-1:0]       sat_count;

   // Environment side: produces sums, consumes results.
   modport master (
      output in_sum, in_bias, in_valid, out_ready,
      input  in_ready, out_data, out_sat, out_valid, sat_count
   );

   // Stage side.
   modport slave (
      input  in_sum, in_bias, in_valid, out_ready,
      output in_ready, out_data, out_sat, out_valid, sat_count
   );
endinterface

// File: rtl/pipe_reg.sv
// Single-entry valid/ready register slice. Accepts a new word whenever it is
// empty or its current word leaves in the same cycle.
module pipe_reg #(
   parameter int unsigned Width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [Width-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [Width-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   logic             valid_q, valid_d;
   logic [Width-1:0] data_q, data_d;

   assign in_ready  = !valid_q || out_ready;
   assign out_data  = data_q;
   assign out_valid = valid_q;

   // Next state: refill or drain when the slot is free; hold while stalled.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (in_ready) begin
         valid_d = in_valid;
         if (in_valid) data_d = in_data;
      end
   end

   // Slot register, cleared on reset so no X reaches downstream logic.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/neuron_activation.sv
// Post-summation neuron stage: bias add, activation, saturation, and a
// two-slot valid/ready pipeline. Define NEURON_ACTIVATION_LEAKY_EN to build
// leaky ReLU (negatives shifted right by LEAK_SHIFT) instead of plain ReLU.
module neuron_activation
   import mlp_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = mlp_pkg::DATA_WIDTH,
   parameter int unsigned LEAK_SHIFT  = 2,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input logic                clk,
   input logic                rst,
   neuron_activation_if.slave bus
);

`ifdef NEURON_ACTIVATION_LEAKY_EN
   localparam bit LeakyEn = 1'b1;
`else
   localparam bit LeakyEn = 1'b0;
`endif

   logic signed [DATA_WIDTH:0] sum_ext;
   logic signed [DATA_WIDTH:0] s1_acc;
   logic signed [DATA_WIDTH:0] act;
   logic signed [DATA_WIDTH:0] leak;
   logic                       s1_in_ready;
   logic                       s1_valid;
   logic                       s2_in_ready;
   logic [DATA_WIDTH:0]        s2_in;
   logic [DATA_WIDTH:0]        s2_q;
   logic                       out_valid;
   logic [COUNT_WIDTH-1:0]     cnt_q, cnt_d;

   // Widen by one bit so the bias add can never overflow.
   assign sum_ext = {bus.in_sum[DATA_WIDTH-1], bus.in_sum}
                  + {bus.in_bias[DATA_WIDTH-1], bus.in_bias};

   // Inputs are refused while reset is held.
   assign bus.in_ready = !rst && s1_in_ready;

   pipe_reg #(
      .Width(DATA_WIDTH + 1)
   ) u_s1 (
      .clk      (clk),
      .rst      (rst),
      .in_data  (sum_ext),
      .in_valid (bus.in_valid),
      .in_ready (s1_in_ready),
      .out_data (s1_acc),
      .out_valid(s1_valid),
      .out_ready(s2_in_ready)
   );

   assign leak = s1_acc >>> LEAK_SHIFT;

   // Activation: positives pass through, negatives go to zero or leak.
   always_comb begin
      act = s1_acc;
      if (s1_acc[DATA_WIDTH]) act = LeakyEn ? leak : '0;
   end

   // Shared clamp when the widths line up; otherwise an equivalent local one.
   if (DATA_WIDTH == mlp_pkg::DATA_WIDTH) begin : g_pkg_sat
      sat_res_t res;
      assign res   = sat_to_data(act);
      assign s2_in = {res.sat, res.data};
   end else begin : g_local_sat
      logic ovf;
      assign ovf   = act[DATA_WIDTH] ^ act[DATA_WIDTH-1];
      assign s2_in = ovf ? {1'b1, act[DATA_WIDTH], {(DATA_WIDTH-1){~act[DATA_WIDTH]}}}
                         : {1'b0, act[DATA_WIDTH-1:0]};
   end

   pipe_reg #(
      .Width(DATA_WIDTH + 1)
   ) u_s2 (
      .clk      (clk),
      .rst      (rst),
      .in_data  (s2_in),
      .in_valid (s1_valid),
      .in_ready (s2_in_ready),
      .out_data (s2_q),
      .out_valid(out_valid),
      .out_ready(bus.out_ready)
   );

   assign bus.out_data  = s2_q[DATA_WIDTH-1:0];
   assign bus.out_sat   = s2_q[DATA_WIDTH];
   assign bus.out_valid = out_valid;
   assign bus.sat_count = cnt_q;

   // Count clamped results as they leave; stick at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (out_valid && bus.out_ready && s2_q[DATA_WIDTH] && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
   end

   // Saturation counter register.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule

// File: tb/tb_neuron_activation.sv
// Directed bench for neuron_activation (DATA_WIDTH=8, LEAK_SHIFT=2). Expected
// values follow NEURON_ACTIVATION_LEAKY_EN the same way the design does.
module tb_neuron_activation;

   localparam int unsigned DW = 8;
   localparam int unsigned LS = 2;
   localparam int unsigned CW = 16;

`ifdef NEURON_ACTIVATION_LEAKY_EN
   localparam int ExpMin = -64;
   localparam int ExpNeg = -2;
   localparam int StreamExp[10] = '{-5, -3, 0, 10, 20, 30, 40, 50, 60, 70};
`else
   localparam int ExpMin = 0;
   localparam int ExpNeg = 0;
   localparam int StreamExp[10] = '{0, 0, 0, 10, 20, 30, 40, 50, 60, 70};
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   neuron_activation_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

   neuron_activation #(
      .DATA_WIDTH (DW),
      .LEAK_SHIFT (LS),
      .COUNT_WIDTH(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_acc    = 0;
   int cyc      = 0;
   int out_q[$];
   int stamp_q[$];

   // Observe every transfer on both sides.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.in_valid && bus.in_ready) n_acc <= n_acc + 1;
      if (bus.out_valid && bus.out_ready) begin
         out_q.push_back(int'(bus.out_data));
         stamp_q.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launched right after edge N: accepted at N+1, out_valid from edge N+2.
   task automatic run_one(input string tag, input int sum, input int bias,
                          input int exp_data, input int exp_sat);
      bus.in_sum   = DW'(sum);
      bus.in_bias  = DW'(bias);
      bus.in_valid = 1'b1;
      @(negedge clk);
      check({tag, "_in_ready"}, bus.in_ready, 1);
      tick();
      bus.in_valid = 1'b0;
      @(negedge clk);
      check({tag, "_early_valid"}, bus.out_valid, 0);
      tick();
      @(negedge clk);
      check({tag, "_valid"}, bus.out_valid, 1);
      check({tag, "_data"}, bus.out_data, exp_data);
      check({tag, "_sat"}, bus.out_sat, exp_sat);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int q0;
      int a0;
      bit ok;

      bus.in_sum    = '0;
      bus.in_bias   = '0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b1;
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 0);
      tick();
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_sat", bus.out_sat, 0);
      check("rst_sat_count", bus.sat_count, 0);
      check("rst_in_ready_after", bus.in_ready, 1);
      check("rst_no_accept", n_acc, 0);
      tick();

      run_one("basic", 40, -10, 30, 0);
      tick();
      run_one("pos_clamp", 100, 50, 127, 1);
      check("pos_clamp_cnt_before", bus.sat_count, 0);
      tick();
      @(negedge clk);
      check("pos_clamp_cnt_after", bus.sat_count, 1);
      tick();
      run_one("min_sum", -128, -128, ExpMin, 0);
      tick();
      run_one("neg", -10, 3, ExpNeg, 0);
      tick();

      // Backpressure: two slots fill, third input waits.
      a0            = n_acc;
      bus.out_ready = 1'b0;
      bus.in_bias   = '0;
      bus.in_sum    = 8'sd1;
      bus.in_valid  = 1'b1;
      tick();
      bus.in_sum = 8'sd2;
      tick();
      bus.in_sum = 8'sd3;
      @(negedge clk);
      check("bp_full_in_ready", bus.in_ready, 0);
      check("bp_full_data", bus.out_data, 1);
      tick();
      @(negedge clk);
      check("bp_accepted", n_acc - a0, 2);
      check("bp_hold_data", bus.out_data, 1);
      check("bp_hold_valid", bus.out_valid, 1);
      bus.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         check("bp_order_valid", bus.out_valid, 1);
         check("bp_order_data", bus.out_data, k + 1);
         tick();
         if (k == 0) bus.in_valid = 1'b0;
         @(negedge clk);
      end
      check("bp_drained", bus.out_valid, 0);
      check("bp_accepted_total", n_acc - a0, 3);
      check("bp_sat_count", bus.sat_count, 1);

      // Streaming at full rate.
      tick();
      q0 = out_q.size();
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus.in_sum   = DW'(i * 10);
         bus.in_bias  = -8'sd20;
         bus.in_valid = 1'b1;
         @(negedge clk);
         if (!bus.in_ready) ok = 1'b0;
         tick();
      end
      bus.in_valid = 1'b0;
      check("stream_in_ready", ok, 1);
      tick();
      tick();
      tick();
      check("stream_count", out_q.size() - q0, 10);
      if (out_q.size() - q0 == 10) begin
         for (int i = 0; i < 10; i++) check("stream_data", out_q[q0 + i], StreamExp[i]);
         check("stream_gapless", stamp_q[q0 + 9] - stamp_q[q0], 9);
      end

      // Reset with two entries in flight.
      bus.out_ready = 1'b0;
      bus.in_sum    = 8'sd5;
      bus.in_valid  = 1'b1;
      tick();
      bus.in_sum = 8'sd6;
      tick();
      @(negedge clk);
      check("mf_full", bus.out_valid, 1);
      a0         = n_acc;
      rst        = 1'b1;
      bus.in_sum = 8'sd7;
      #1;
      check("mf_rst_in_ready", bus.in_ready, 0);
      tick();
      rst           = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      q0            = out_q.size();
      @(negedge clk);
      check("mf_out_valid", bus.out_valid, 0);
      check("mf_out_data", bus.out_data, 0);
      check("mf_sat_count", bus.sat_count, 0);
      tick();
      tick();
      tick();
      check("mf_no_stale", out_q.size() - q0, 0);
      check("mf_no_accept", n_acc - a0, 0);
      run_one("post_rst", 20, 7, 27, 0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
